// File: rtl/repopulate_pkg.sv
// Shared GA constants: default population geometry, LFSR feedback polynomial, stage FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package repopulate_pkg;

  localparam int GA_NUM_SEL  = 10;
  localparam int GA_NUM_POP  = 50;
  localparam int GA_IND_BITS = 150;

  // Galois feedback taps for the 32-bit right-shifting LFSR; shared with future mutation logic.
  localparam logic [31:0] GA_LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } ga_state_e;

endpackage

// File: rtl/ga_lfsr32.sv
// 32-bit Galois LFSR (right shift), advances one step per cycle while en_i is high.
// Latency: new state visible the cycle after an enabled edge.
// Backpressure: none; en_i simply holds the state.
module ga_lfsr32
  import repopulate_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Next state: shift right, fold the taps back in when a one falls off the bottom.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? GA_LFSR_POLY : 32'h0);
    end
  end

  // State register; only reset ever reloads the seed, so runs continue the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/repopulate.sv
// Regrows NUM_POP individuals from NUM_SEL parents: elite copies, then LFSR crossover + optional mutation.
// Latency: done pulses in the cycle after the (NUM_POP+1)th edge following the start edge.
// Backpressure: none; start is ignored unless IDLE, sel_pop is latched on the accepted start edge.
module repopulate
  import repopulate_pkg::*;
#(
  parameter int          NUM_SEL  = GA_NUM_SEL,
  parameter int          NUM_POP  = GA_NUM_POP,
  parameter int          IND_BITS = GA_IND_BITS,
  parameter logic [31:0] SEED     = 32'hACE1_2468,
  parameter int          MUT_RATE = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_SEL*IND_BITS-1:0]  sel_pop,
  output logic [NUM_POP*IND_BITS-1:0]  pop,
  output logic                         busy,
  output logic                         done
);

  // Count must also hold NUM_POP, the value it reaches after the last write.
  localparam int CW = $clog2(NUM_POP + 1);

  ga_state_e                   state_q;
  logic [CW-1:0]               count_q;
  logic [NUM_SEL*IND_BITS-1:0] parents_q;
  logic [NUM_POP*IND_BITS-1:0] pop_q;
  logic                        busy_q;
  logic                        done_q;

  logic [31:0]                 lfsr_state;
  logic                        elite;
  logic                        lfsr_en;
  logic [IND_BITS-1:0]         child_d;

  // Crossover of two distinct parents at an LFSR-chosen cut, with an optional single-bit flip.
  function automatic logic [IND_BITS-1:0] build_child(
    input logic [31:0]                 r,
    input logic [NUM_SEL*IND_BITS-1:0] par
  );
    int                  a;
    int                  b;
    int                  cut;
    int                  mpos;
    logic [IND_BITS-1:0] pa;
    logic [IND_BITS-1:0] pb;
    logic [IND_BITS-1:0] low_mask;
    logic [IND_BITS-1:0] child;
    a    = int'(r[7:0]) % NUM_SEL;
    // Offset in 1..NUM_SEL-1 guarantees b differs from a.
    b    = (a + 1 + int'(r[19:16]) % (NUM_SEL - 1)) % NUM_SEL;
    cut  = int'(r[15:8]) % IND_BITS;
    mpos = int'(r[31:24]) % IND_BITS;
    pa   = '0;
    pb   = '0;
    for (int k = 0; k < NUM_SEL; k++) begin
      if (a == k) pa = par[k*IND_BITS +: IND_BITS];
      if (b == k) pb = par[k*IND_BITS +: IND_BITS];
    end
    // Bits below cut come from a; cut == 0 yields a plain copy of b.
    low_mask = ~({IND_BITS{1'b1}} << cut);
    child    = (pa & low_mask) | (pb & ~low_mask);
    if (int'(r[23:20]) < MUT_RATE) begin
      child = child ^ ({{(IND_BITS-1){1'b0}}, 1'b1} << mpos);
    end
    return child;
  endfunction

  assign elite   = (count_q < CW'(NUM_SEL));
  // The LFSR only moves on crossover children, never on elite copies.
  assign lfsr_en = (state_q == ST_GEN) && !elite;

  ga_lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (lfsr_en),
    .state_o (lfsr_state)
  );

  // Child for the current slot: verbatim parent while elite, otherwise crossover result.
  always_comb begin
    child_d = '0;
    for (int k = 0; k < NUM_SEL; k++) begin
      if (count_q == CW'(k)) child_d = parents_q[k*IND_BITS +: IND_BITS];
    end
    if (!elite) begin
      child_d = build_child(lfsr_state, parents_q);
    end
  end

  // Control FSM with registered busy/done and the progressively written population.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      parents_q <= '0;
      pop_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            parents_q <= sel_pop;
            count_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_GEN;
          end
        end
        ST_GEN: begin
          for (int k = 0; k < NUM_POP; k++) begin
            if (count_q == CW'(k)) pop_q[k*IND_BITS +: IND_BITS] <= child_d;
          end
          count_q <= count_q + 1'b1;
          if (count_q == CW'(NUM_POP - 1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pop  = pop_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
